// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU codes,
// sequencer steps, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned IR_W  = 32;

    localparam logic [OP_W-1:0] OP_LD   = 5'd0;
    localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OP_W-1:0] OP_ST   = 5'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OP_W-1:0] OP_AND  = 5'd5;
    localparam logic [OP_W-1:0] OP_OR   = 5'd6;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd7;
    localparam logic [OP_W-1:0] OP_SHRA = 5'd8;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd9;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd10;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd11;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd15;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd16;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd17;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
    localparam logic [OP_W-1:0] OP_BR   = 5'd19;
    localparam logic [OP_W-1:0] OP_JR   = 5'd20;
    localparam logic [OP_W-1:0] OP_JAL  = 5'd21;
    localparam logic [OP_W-1:0] OP_IN   = 5'd22;
    localparam logic [OP_W-1:0] OP_OUT  = 5'd23;
    localparam logic [OP_W-1:0] OP_MFHI = 5'd24;
    localparam logic [OP_W-1:0] OP_MFLO = 5'd25;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OP_W-1:0] OP_HALT = 5'd27;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SHR  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SHRA = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SHL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_ROR  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_ROL  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_MUL  = 4'd9;
    localparam logic [ALU_W-1:0] ALU_DIV  = 4'd10;
    localparam logic [ALU_W-1:0] ALU_NEG  = 4'd11;
    localparam logic [ALU_W-1:0] ALU_NOT  = 4'd12;

    // Sequencer step; values are ordered so T0..T7 can be compared/incremented.
    typedef enum logic [3:0] {
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } step_e;

    // Instruction classes sharing one execute sequence.
    typedef enum logic [3:0] {
        CL_NOP, CL_ALU3, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_ST, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
    } iclass_e;

    // Every datapath strobe driven by the control unit.
    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout, cout;
        logic hiin, loin, pcin, irin, yin, zin, marin, mdrin, outportin, conin;
        logic hiout, loout, pcout, mdrout, zlowout, zhighout, inportout;
        logic incpc, mdrread, memwrite;
        logic [ALU_W-1:0] alu_sel;
    } ctrl_t;

endpackage

// File: rtl/control_unit_op_decode.sv
// Opcode decoder: maps an opcode to its execute class, ALU code and the
// last execute step of that class.
module control_unit_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  opcode,
    output iclass_e          iclass_c,
    output logic [ALU_W-1:0] alu_sel_c,
    output step_e            last_step_c
);

    // Class and ALU operation per opcode; undefined opcodes behave as nop.
    always_comb begin
        iclass_c  = CL_NOP;
        alu_sel_c = ALU_ADD;
        case (opcode)
            OP_LD:   iclass_c = CL_LD;
            OP_ST:   iclass_c = CL_ST;
            OP_LDI:  iclass_c = CL_IMM;
            OP_ADDI: iclass_c = CL_IMM;
            OP_ANDI: begin iclass_c = CL_IMM;    alu_sel_c = ALU_AND;  end
            OP_ORI:  begin iclass_c = CL_IMM;    alu_sel_c = ALU_OR;   end
            OP_ADD:  iclass_c = CL_ALU3;
            OP_SUB:  begin iclass_c = CL_ALU3;   alu_sel_c = ALU_SUB;  end
            OP_AND:  begin iclass_c = CL_ALU3;   alu_sel_c = ALU_AND;  end
            OP_OR:   begin iclass_c = CL_ALU3;   alu_sel_c = ALU_OR;   end
            OP_SHR:  begin iclass_c = CL_ALU3;   alu_sel_c = ALU_SHR;  end
            OP_SHRA: begin iclass_c = CL_ALU3;   alu_sel_c = ALU_SHRA; end
            OP_SHL:  begin iclass_c = CL_ALU3;   alu_sel_c = ALU_SHL;  end
            OP_ROR:  begin iclass_c = CL_ALU3;   alu_sel_c = ALU_ROR;  end
            OP_ROL:  begin iclass_c = CL_ALU3;   alu_sel_c = ALU_ROL;  end
            OP_MUL:  begin iclass_c = CL_MULDIV; alu_sel_c = ALU_MUL;  end
            OP_DIV:  begin iclass_c = CL_MULDIV; alu_sel_c = ALU_DIV;  end
            OP_NEG:  begin iclass_c = CL_UNARY;  alu_sel_c = ALU_NEG;  end
            OP_NOT:  begin iclass_c = CL_UNARY;  alu_sel_c = ALU_NOT;  end
            OP_BR:   iclass_c = CL_BR;
            OP_JR:   iclass_c = CL_JR;
            OP_JAL:  iclass_c = CL_JAL;
            OP_IN:   iclass_c = CL_IN;
            OP_OUT:  iclass_c = CL_OUT;
            OP_MFHI: iclass_c = CL_MFHI;
            OP_MFLO: iclass_c = CL_MFLO;
            OP_HALT: iclass_c = CL_HALT;
            default: iclass_c = CL_NOP;
        endcase
    end

    // Final execute step per class; single-step classes end in T3.
    always_comb begin
        last_step_c = ST_T3;
        case (iclass_c)
            CL_ALU3, CL_IMM:   last_step_c = ST_T5;
            CL_UNARY, CL_JAL:  last_step_c = ST_T4;
            CL_MULDIV, CL_BR:  last_step_c = ST_T6;
            CL_LD, CL_ST:      last_step_c = ST_T7;
            default:           last_step_c = ST_T3;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the CPU datapath.
// Optional CU_MEM_WAIT_EN: adds mem_ready and stalls memory steps until it is high.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic [IR_W-1:0]  ir,
    input  logic             con_out,
`ifdef CU_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             run,
    output logic             Gra, Grb, Grc,
    output logic             Rin, Rout, BAout, Cout,
    output logic             HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin, outPortin, conIn,
    output logic             HIout, LOout, PCout, MDRout, ZLowout, ZHighout, InPortout,
    output logic             IncPC, MDRread, memWrite,
    output logic [ALU_W-1:0] ALUselect
);

    step_e            step;
    iclass_e          iclass;
    logic [ALU_W-1:0] alu_sel;
    step_e            last_step;
    ctrl_t            ctrl;
    logic             hold_c;
    logic             unused_ir_fields;

    // Only the opcode field matters here; register fields go to sel_enc directly.
    assign unused_ir_fields = ^ir[IR_W-OP_W-1:0];

    control_unit_op_decode u_op_decode (
        .opcode      (ir[IR_W-1:IR_W-OP_W]),
        .iclass_c    (iclass),
        .alu_sel_c   (alu_sel),
        .last_step_c (last_step)
    );

    // Strobe decode of (step, class); everything is gated off unless running.
    always_comb begin
        ctrl = '0;
        if (run) begin
            case (step)
                ST_T0: begin ctrl.pcout = 1'b1; ctrl.marin = 1'b1; ctrl.incpc = 1'b1; end
                ST_T1: begin ctrl.mdrread = 1'b1; ctrl.mdrin = 1'b1; end
                ST_T2: begin ctrl.mdrout = 1'b1; ctrl.irin = 1'b1; end
                ST_T3: case (iclass)
                    CL_ALU3:             begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
                    CL_IMM, CL_LD, CL_ST: begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yin = 1'b1; end
                    CL_UNARY:            begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_sel = alu_sel; end
                    CL_MULDIV:           begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
                    CL_BR:               begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1; end
                    CL_JR:               begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1; end
                    CL_JAL:              begin ctrl.pcout = 1'b1; ctrl.grb = 1'b1; ctrl.rin = 1'b1; end
                    CL_IN:               begin ctrl.inportout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_OUT:              begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outportin = 1'b1; end
                    CL_MFHI:             begin ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_MFLO:             begin ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    default: ;
                endcase
                ST_T4: case (iclass)
                    CL_ALU3:             begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_sel = alu_sel; end
                    CL_IMM, CL_LD, CL_ST: begin ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_sel = alu_sel; end
                    CL_UNARY:            begin ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_MULDIV:           begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_sel = alu_sel; end
                    CL_BR:               begin ctrl.pcout = 1'b1; ctrl.yin = 1'b1; end
                    CL_JAL:              begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1; end
                    default: ;
                endcase
                ST_T5: case (iclass)
                    CL_ALU3, CL_IMM:     begin ctrl.zlowout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_MULDIV:           begin ctrl.zlowout = 1'b1; ctrl.loin = 1'b1; end
                    CL_LD, CL_ST:        begin ctrl.zlowout = 1'b1; ctrl.marin = 1'b1; end
                    CL_BR:               begin ctrl.cout = 1'b1; ctrl.zin = 1'b1; ctrl.alu_sel = alu_sel; end
                    default: ;
                endcase
                ST_T6: case (iclass)
                    CL_MULDIV:           begin ctrl.zhighout = 1'b1; ctrl.hiin = 1'b1; end
                    CL_LD:               begin ctrl.mdrread = 1'b1; ctrl.mdrin = 1'b1; end
                    CL_ST:               begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdrin = 1'b1; end
                    CL_BR:               begin ctrl.zlowout = con_out; ctrl.pcin = con_out; end
                    default: ;
                endcase
                ST_T7: case (iclass)
                    CL_LD:               begin ctrl.mdrout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    CL_ST:               ctrl.memwrite = 1'b1;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

`ifdef CU_MEM_WAIT_EN
    // Memory steps stretch until the memory reports completion.
    assign hold_c = (ctrl.mdrread | ctrl.memwrite) & ~mem_ready;
`else
    assign hold_c = 1'b0;
`endif

    // Step sequencer: start on the first edge after clr, advance, wrap or halt.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step <= ST_T0;
            run  <= 1'b0;
        end else if (step == ST_HALT) begin
            run <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (!hold_c) begin
            if (step >= ST_T3 && step >= last_step) begin
                if (iclass == CL_HALT) begin
                    step <= ST_HALT;
                    run  <= 1'b0;
                end else begin
                    step <= ST_T0;
                end
            end else begin
                step <= step_e'(4'(step) + 4'd1);
            end
        end
    end

    assign Gra = ctrl.gra;       assign Grb = ctrl.grb;         assign Grc = ctrl.grc;
    assign Rin = ctrl.rin;       assign Rout = ctrl.rout;       assign BAout = ctrl.baout;
    assign Cout = ctrl.cout;     assign HIin = ctrl.hiin;       assign LOin = ctrl.loin;
    assign PCin = ctrl.pcin;     assign IRin = ctrl.irin;       assign Yin = ctrl.yin;
    assign Zin = ctrl.zin;       assign MARin = ctrl.marin;     assign MDRin = ctrl.mdrin;
    assign outPortin = ctrl.outportin;                          assign conIn = ctrl.conin;
    assign HIout = ctrl.hiout;   assign LOout = ctrl.loout;     assign PCout = ctrl.pcout;
    assign MDRout = ctrl.mdrout; assign ZLowout = ctrl.zlowout; assign ZHighout = ctrl.zhighout;
    assign InPortout = ctrl.inportout;                          assign IncPC = ctrl.incpc;
    assign MDRread = ctrl.mdrread;                              assign memWrite = ctrl.memwrite;
    assign ALUselect = ctrl.alu_sel;

endmodule
